// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N-channel select mux feeding a two-entry elastic output stage
// (main + skid register) with a valid/ready handshake on both sides.
module mux_n_pipe #(
  parameter int DATA_W = 16,
  parameter int N_IN   = 4,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_IN*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_sel_err,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int N_TBL = 1 << SEL_W;
  localparam logic [SEL_W:0] N_IN_L = (SEL_W + 1)'(N_IN);

  // Encoding is {main_v, skid_v}; 2'b01 cannot be reached.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t            state_r, state_s;
  logic [DATA_W-1:0] main_data_r, skid_data_r, dec_data_s;
  logic              main_err_r, skid_err_r, dec_err_s;
  logic              main_v_s, skid_v_s;
  logic              in_xfer_s, out_xfer_s;
  logic              load_main_s, load_skid_s, skid_to_main_s;
  logic [DATA_W-1:0] tbl_s [N_TBL];

  // Select codes beyond N_IN-1 alias the last channel, so the table has no holes.
  for (genvar k = 0; k < N_TBL; k++) begin : g_tbl
    localparam int SRC = (k < N_IN) ? k : N_IN - 1;
    assign tbl_s[k] = in_data[SRC*DATA_W +: DATA_W];
  end

  assign main_v_s    = state_r[1];
  assign skid_v_s    = state_r[0];
  assign in_ready    = ~skid_v_s;
  assign in_xfer_s   = in_valid & ~skid_v_s;
  assign out_xfer_s  = main_v_s & out_ready;
  assign out_valid   = main_v_s;
  assign out_data    = main_data_r;
  assign out_sel_err = main_err_r;

  // Input-side select decode, captured alongside the data.
  always_comb begin
    dec_data_s = tbl_s[in_sel];
    dec_err_s  = ({1'b0, in_sel} >= N_IN_L);
  end

  // Next-state and register load enables for the main/skid pair.
  always_comb begin
    state_s        = state_r;
    load_main_s    = 1'b0;
    load_skid_s    = 1'b0;
    skid_to_main_s = 1'b0;
    case (state_r)
      EMPTY: begin
        if (in_xfer_s) begin
          load_main_s = 1'b1;
          state_s     = ONE;
        end else begin
          state_s = EMPTY;
        end
      end
      ONE: begin
        if (in_xfer_s && out_xfer_s) begin
          load_main_s = 1'b1;
          state_s     = ONE;
        end else if (in_xfer_s) begin
          load_skid_s = 1'b1;
          state_s     = FULL;
        end else if (out_xfer_s) begin
          state_s = EMPTY;
        end else begin
          state_s = ONE;
        end
      end
      FULL: begin
        if (out_xfer_s) begin
          skid_to_main_s = 1'b1;
          state_s        = ONE;
        end else begin
          state_s = FULL;
        end
      end
      default: begin
        state_s = EMPTY;
      end
    endcase
  end

  // State, main and skid registers; reset discards any stored words.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= EMPTY;
      main_data_r <= '0;
      main_err_r  <= 1'b0;
      skid_data_r <= '0;
      skid_err_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      if (load_main_s) begin
        main_data_r <= dec_data_s;
        main_err_r  <= dec_err_s;
      end else if (skid_to_main_s) begin
        main_data_r <= skid_data_r;
        main_err_r  <= skid_err_r;
      end
      if (load_skid_s) begin
        skid_data_r <= dec_data_s;
        skid_err_r  <= dec_err_s;
      end
    end
  end

endmodule

// File: tb/tb_mux_n_pipe.sv
// Scoreboard bench for mux_n_pipe: directed tests on N_IN=4 and N_IN=3 instances,
// plus randomised traffic on N_IN=2/8/16 x DATA_W=8/32 instances.
module tb_mux_n_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int sw_done = 0;

  task automatic record(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic mark_done();
    sw_done++;
  endtask

  // ---------------- DUT A: N_IN=4, DATA_W=16 ----------------
  logic        a_rst, a_in_valid, a_in_ready, a_out_err, a_out_valid, a_out_ready;
  logic [63:0] a_in_data;
  logic [1:0]  a_in_sel;
  logic [15:0] a_out_data, a_exp_data;
  logic        a_exp_err;
  logic [16:0] a_q [$];
  logic [16:0] a_pop;
  logic [15:0] cha [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

  mux_n_pipe #(.DATA_W(16), .N_IN(4)) u_a (
    .clk(clk), .rst(a_rst), .in_data(a_in_data), .in_sel(a_in_sel),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
    .out_sel_err(a_out_err), .out_valid(a_out_valid), .out_ready(a_out_ready));

  always @(negedge clk) begin
    if (a_rst) begin
      a_q.delete();
    end else begin
      if (a_out_valid && a_out_ready) begin
        if (a_q.size() == 0) begin
          record(1'b0, "a_unexpected_word", 64'({a_out_err, a_out_data}), 64'd0);
        end else begin
          a_pop = a_q.pop_front();
          record({a_out_err, a_out_data} == a_pop, "a_word", 64'({a_out_err, a_out_data}), 64'(a_pop));
        end
      end
      if (a_in_valid && a_in_ready) a_q.push_back({a_exp_err, a_exp_data});
    end
  end

  // ---------------- DUT B: N_IN=3, DATA_W=16 ----------------
  logic        b_rst, b_in_valid, b_in_ready, b_out_err, b_out_valid, b_out_ready;
  logic [47:0] b_in_data;
  logic [1:0]  b_in_sel;
  logic [15:0] b_out_data, b_exp_data;
  logic        b_exp_err;
  logic [16:0] b_q [$];
  logic [16:0] b_pop;

  mux_n_pipe #(.DATA_W(16), .N_IN(3)) u_b (
    .clk(clk), .rst(b_rst), .in_data(b_in_data), .in_sel(b_in_sel),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
    .out_sel_err(b_out_err), .out_valid(b_out_valid), .out_ready(b_out_ready));

  always @(negedge clk) begin
    if (b_rst) begin
      b_q.delete();
    end else begin
      if (b_out_valid && b_out_ready) begin
        if (b_q.size() == 0) begin
          record(1'b0, "b_unexpected_word", 64'({b_out_err, b_out_data}), 64'd0);
        end else begin
          b_pop = b_q.pop_front();
          record({b_out_err, b_out_data} == b_pop, "b_word", 64'({b_out_err, b_out_data}), 64'(b_pop));
        end
      end
      if (b_in_valid && b_in_ready) b_q.push_back({b_exp_err, b_exp_data});
    end
  end

  // ---------------- Sweep instances ----------------
  localparam int SW_N [6] = '{2, 8, 16, 2, 8, 16};
  localparam int SW_W [6] = '{8, 8, 8, 32, 32, 32};

  for (genvar g = 0; g < 6; g++) begin : g_sw
    localparam int N  = SW_N[g];
    localparam int W  = SW_W[g];
    localparam int SW = $clog2(N);
    logic           s_rst, s_in_valid, s_in_ready, s_out_err, s_out_valid, s_out_ready;
    logic [N*W-1:0] s_in_data;
    logic [SW-1:0]  s_in_sel;
    logic [W-1:0]   s_out_data;
    logic [W:0]     s_exp, s_pop;
    logic [W:0]     s_q [$];

    mux_n_pipe #(.DATA_W(W), .N_IN(N)) u_dut (
      .clk(clk), .rst(s_rst), .in_data(s_in_data), .in_sel(s_in_sel),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .out_data(s_out_data),
      .out_sel_err(s_out_err), .out_valid(s_out_valid), .out_ready(s_out_ready));

    initial begin
      int idx;
      int t;
      s_rst = 1'b1; s_in_valid = 1'b0; s_in_data = '0; s_in_sel = '0; s_exp = '0;
      repeat (2) @(posedge clk);
      #1 s_rst = 1'b0;
      for (int k = 0; k < 40; k++) begin
        while ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        for (int b = 0; b < N*W; b++) s_in_data[b] = 1'($urandom_range(0, 1));
        s_in_sel = SW'($urandom_range(0, (1 << SW) - 1));
        idx = int'(s_in_sel);
        if (idx >= N) idx = N - 1;
        s_exp[W]     = (int'(s_in_sel) >= N);
        s_exp[W-1:0] = s_in_data[idx*W +: W];
        s_in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!s_in_ready && t < 100) begin t++; @(negedge clk); end
        if (t >= 100) record(1'b0, "sw_accept_timeout", 64'(t), 64'd100);
        @(posedge clk); #1;
        s_in_valid = 1'b0;
      end
      t = 0;
      while (s_q.size() != 0 && t < 200) begin t++; @(posedge clk); end
      record(s_q.size() == 0, "sw_drain", 64'(s_q.size()), 64'd0);
      mark_done();
    end

    initial begin
      s_out_ready = 1'b0;
      forever begin
        @(posedge clk); #1;
        s_out_ready = 1'($urandom_range(0, 1));
      end
    end

    always @(negedge clk) begin
      if (s_rst) begin
        s_q.delete();
      end else begin
        if (s_out_valid && s_out_ready) begin
          if (s_q.size() == 0) begin
            record(1'b0, "sw_unexpected_word", 64'({s_out_err, s_out_data}), 64'd0);
          end else begin
            s_pop = s_q.pop_front();
            record({s_out_err, s_out_data} == s_pop, "sw_word", 64'({s_out_err, s_out_data}), 64'(s_pop));
          end
        end
        if (s_in_valid && s_in_ready) s_q.push_back(s_exp);
      end
    end
  end

  // Offer word w on channel sel of DUT A and wait until it is accepted; valid stays high.
  task automatic a_send(input logic [1:0] sel, input logic [15:0] w);
    int t = 0;
    a_in_data = {4{~w}};
    a_in_data[int'(sel)*16 +: 16] = w;
    a_in_sel = sel; a_exp_data = w; a_exp_err = 1'b0; a_in_valid = 1'b1;
    @(negedge clk);
    while (!a_in_ready && t < 50) begin t++; @(negedge clk); end
    record(a_in_ready == 1'b1, "a_send_accept", 64'(a_in_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic b_send(input logic [1:0] sel, input logic [15:0] w, input logic e);
    int t = 0;
    b_in_sel = sel; b_exp_data = w; b_exp_err = e; b_in_valid = 1'b1;
    @(negedge clk);
    while (!b_in_ready && t < 50) begin t++; @(negedge clk); end
    record(b_in_ready == 1'b1, "b_send_accept", 64'(b_in_ready), 64'd1);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    @(negedge clk);
    record(b_out_valid == 1'b1 && b_out_err == e, "b_err_flag", 64'({b_out_valid, b_out_err}), 64'({1'b1, e}));
    @(posedge clk); #1;
  endtask

  initial begin
    int t;
    a_rst = 1'b1; a_in_valid = 1'b1; a_in_sel = 2'd0; a_in_data = {4{16'hDEAD}};
    a_exp_data = 16'hDEAD; a_exp_err = 1'b0; a_out_ready = 1'b1;
    b_rst = 1'b1; b_in_valid = 1'b0; b_in_sel = 2'd0;
    b_in_data = {16'hC0DE, 16'h0B11, 16'h0B00}; b_exp_data = 16'h0; b_exp_err = 1'b0; b_out_ready = 1'b1;

    // Reset: two edges, with an input offered that must be ignored
    @(posedge clk); #1;
    @(negedge clk);
    record(a_out_valid == 1'b0, "rst_out_valid", 64'(a_out_valid), 64'd0);
    record(a_in_ready == 1'b1, "rst_in_ready", 64'(a_in_ready), 64'd1);
    record(a_out_data == 16'h0000, "rst_out_data", 64'(a_out_data), 64'd0);
    record(a_out_err == 1'b0, "rst_out_err", 64'(a_out_err), 64'd0);
    @(posedge clk); #1;
    a_rst = 1'b0; b_rst = 1'b0; a_in_valid = 1'b0;
    @(negedge clk);
    record(a_out_valid == 1'b0, "rst_no_accept", 64'(a_out_valid), 64'd0);
    @(posedge clk); #1;

    // Stream: sel 0..3 back-to-back
    a_in_data = {cha[3], cha[2], cha[1], cha[0]};
    for (int i = 0; i < 4; i++) begin
      a_in_sel = 2'(i); a_exp_data = cha[i]; a_exp_err = 1'b0; a_in_valid = 1'b1;
      @(negedge clk);
      record(a_in_ready == 1'b1, "stream_in_ready", 64'(a_in_ready), 64'd1);
      record(a_out_valid == (i != 0), "stream_out_valid", 64'(a_out_valid), 64'(i != 0));
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    // Backpressure fill
    a_out_ready = 1'b0;
    a_send(2'd0, 16'h00AA);
    a_send(2'd1, 16'h00BB);
    a_in_data = {4{16'hFF33}}; a_in_data[47:32] = 16'h00CC;
    a_in_sel = 2'd2; a_exp_data = 16'h00CC; a_exp_err = 1'b0; a_in_valid = 1'b1;
    @(negedge clk);
    record(a_in_ready == 1'b0, "bp_full", 64'(a_in_ready), 64'd0);
    record(a_out_data == 16'h00AA, "bp_head", 64'(a_out_data), 64'h00AA);
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    @(negedge clk);
    record(a_in_ready == 1'b0, "bp_still_full", 64'(a_in_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    record(a_in_ready == 1'b1, "bp_ready_back", 64'(a_in_ready), 64'd1);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    // Simultaneous in/out while one word is held
    a_out_ready = 1'b0;
    a_send(2'd3, 16'hD000);
    a_out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      a_in_data = {4{16'hEEEE}}; a_in_data[(i % 4)*16 +: 16] = 16'hD000 + 16'(i);
      a_in_sel = 2'(i % 4); a_exp_data = 16'hD000 + 16'(i); a_exp_err = 1'b0; a_in_valid = 1'b1;
      @(negedge clk);
      record(a_in_ready == 1'b1, "one_in_ready", 64'(a_in_ready), 64'd1);
      record(a_out_valid == 1'b1, "one_out_valid", 64'(a_out_valid), 64'd1);
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    // Reset while FULL
    a_out_ready = 1'b0;
    a_send(2'd0, 16'h1234);
    a_send(2'd2, 16'h5678);
    a_in_valid = 1'b0;
    @(negedge clk);
    record(a_in_ready == 1'b0, "rm_full", 64'(a_in_ready), 64'd0);
    @(posedge clk); #1;
    a_rst = 1'b1;
    @(posedge clk); #1;
    a_rst = 1'b0; a_out_ready = 1'b1;
    @(negedge clk);
    record(a_out_valid == 1'b0, "rm_out_valid", 64'(a_out_valid), 64'd0);
    record(a_in_ready == 1'b1, "rm_in_ready", 64'(a_in_ready), 64'd1);
    record(a_out_data == 16'h0000, "rm_out_data", 64'(a_out_data), 64'd0);
    @(posedge clk); #1;
    a_send(2'd1, 16'h5A5A);
    a_in_valid = 1'b0;
    @(negedge clk);
    record(a_out_valid == 1'b1 && a_out_data == 16'h5A5A, "rm_word",
           64'({a_out_valid, a_out_data}), 64'({1'b1, 16'h5A5A}));
    @(posedge clk); #1;
    @(negedge clk);
    record(a_out_valid == 1'b0, "rm_alone", 64'(a_out_valid), 64'd0);

    // Out-of-range select on N_IN=3
    b_send(2'd3, 16'hC0DE, 1'b1);
    b_send(2'd2, 16'hC0DE, 1'b0);
    b_send(2'd0, 16'h0B00, 1'b0);
    b_send(2'd1, 16'h0B11, 1'b0);

    t = 0;
    while (sw_done < 6 && t < 20000) begin t++; @(posedge clk); end
    record(sw_done == 6, "sweep_done", 64'(sw_done), 64'd6);
    record(a_q.size() == 0, "a_drain", 64'(a_q.size()), 64'd0);
    record(b_q.size() == 0, "b_drain", 64'(b_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
